spi_cmd_rx: RTL and testbench

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

---
 rtl/spi_cmd_rx.sv | 167 ++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_rx.sv
// SPI (mode 0, MSB first) command-word receiver with a valid/ready output register.
// Optional odd parity bit appended to each frame when SPI_CMD_PARITY_EN is defined.
module spi_cmd_rx #(
  parameter int unsigned FRAME_W = 16
) (
  input  logic               CLK50M,
  input  logic               RESET,
  input  logic               SPI_CS,
  input  logic               SPI_CLK,
  input  logic               SPI_MOSI,
  output logic [FRAME_W-1:0] CMD_DATA,
  output logic               CMD_VALID,
  input  logic               CMD_READY,
  output logic               FRM_ERR,
  output logic               OVF
);

`ifdef SPI_CMD_PARITY_EN
  localparam int unsigned FrameLen = FRAME_W + 1;
  localparam int unsigned SrW      = FRAME_W;
`else
  localparam int unsigned FrameLen = FRAME_W;
  localparam int unsigned SrW      = FRAME_W - 1;
`endif
  localparam int unsigned CntW = $clog2(FrameLen + 1);

  typedef enum logic [1:0] {StIdle, StShift, StWaitCs} state_e;

  logic [1:0] cs_sync_q, clk_sync_q, mosi_sync_q;
  logic       cs_prev_q, clk_prev_q;
  logic       cs_s, clk_s, mosi_s;
  logic       cs_fall, cs_rise, clk_rise;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [SrW-1:0]     shift_q, shift_d;
  logic               edge_seen_q, edge_seen_d;
  logic [1:0]         rst_win_q, rst_win_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               frm_err_q, frm_err_d;
  logic               ovf_q, ovf_d;

  logic               frame_done, frame_ok, load;
  logic [FRAME_W-1:0] word;

  assign cs_s     = cs_sync_q[1];
  assign clk_s    = clk_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign clk_rise = ~clk_prev_q & clk_s;

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      cs_sync_q   <= 2'b11;
      clk_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_prev_q   <= 1'b1;
      clk_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], SPI_CS};
      clk_sync_q  <= {clk_sync_q[0], SPI_CLK};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
      cs_prev_q   <= cs_s;
      clk_prev_q  <= clk_s;
    end
  end

  // Word as it stands once the final frame bit is taken on this cycle.
`ifdef SPI_CMD_PARITY_EN
  assign word     = shift_q;
  assign frame_ok = frame_done & (^{shift_q, mosi_s});
`else
  assign word     = {shift_q, mosi_s};
  assign frame_ok = frame_done;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    edge_seen_d = edge_seen_q;
    frame_done  = 1'b0;
    frm_err_d   = 1'b0;
    rst_win_d   = (rst_win_q != 2'd0) ? rst_win_q - 2'd1 : rst_win_q;

    unique case (state_q)
      StIdle: begin
        // Right after reset the synchronizer is just settling; a low CS here
        // means a frame already in flight, which must not be delivered.
        if (rst_win_q != 2'd0 && !cs_s) begin
          state_d     = StWaitCs;
          edge_seen_d = 1'b0;
        end else if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          state_d   = StIdle;
          frm_err_d = 1'b1;
        end else if (clk_rise) begin
          shift_d = {shift_q[SrW-2:0], mosi_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CntW'(FrameLen - 1)) begin
            frame_done  = 1'b1;
            state_d     = StWaitCs;
            edge_seen_d = 1'b0;
          end
        end
      end
      StWaitCs: begin
        if (cs_rise) begin
          state_d   = StIdle;
          frm_err_d = edge_seen_q;
        end else if (clk_rise) begin
          edge_seen_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_done && !frame_ok) begin
      frm_err_d = 1'b1;
    end
  end

  always_comb begin
    load    = frame_ok & (~valid_q | CMD_READY);
    ovf_d   = frame_ok & valid_q & ~CMD_READY;
    data_d  = load ? word : data_q;
    valid_d = load | (valid_q & ~CMD_READY);
  end

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      edge_seen_q <= 1'b0;
      rst_win_q   <= 2'd3;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frm_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      edge_seen_q <= edge_seen_d;
      rst_win_q   <= rst_win_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frm_err_q   <= frm_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign CMD_DATA  = data_q;
  assign CMD_VALID = valid_q;
  assign FRM_ERR   = frm_err_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed self-checking bench for spi_cmd_rx; follows SPI_CMD_PARITY_EN when defined.
module tb_spi_cmd_rx;
  localparam int unsigned FW = 16;
  localparam int Half = 5;
`ifdef SPI_CMD_PARITY_EN
  localparam int FLen = 17;
`else
  localparam int FLen = 16;
`endif

  logic          clk = 1'b0;
  logic          rst, cs, sclk, mosi, ready;
  logic [FW-1:0] data;
  logic          valid, frm_err, ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int xfer_cnt = 0, vcyc = 0, frm_cnt = 0, ovf_cnt = 0;
  int valid_rise_cyc = 0, last_rise_cyc = 0;
  logic [FW-1:0] last_data = '0;
  logic prev_valid = 1'b0;

  spi_cmd_rx #(.FRAME_W(FW)) dut (
    .CLK50M   (clk),
    .RESET    (rst),
    .SPI_CS   (cs),
    .SPI_CLK  (sclk),
    .SPI_MOSI (mosi),
    .CMD_DATA (data),
    .CMD_VALID(valid),
    .CMD_READY(ready),
    .FRM_ERR  (frm_err),
    .OVF      (ovf)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_data <= data;
    end
    if (valid) vcyc <= vcyc + 1;
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (ovf) ovf_cnt <= ovf_cnt + 1;
    if (valid && !prev_valid) valid_rise_cyc <= cyc;
    prev_valid <= valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_send(input logic [31:0] bits, input int n, input int rst_after);
    cs = 1'b0;
    tick(6);
    for (int i = 0; i < n; i++) begin
      mosi = bits[n-1-i];
      tick(Half);
      sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(Half);
      sclk = 1'b0;
      if (i + 1 == rst_after) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    end
    tick(Half);
    cs = 1'b1;
    tick(12);
  endtask

  function automatic logic [31:0] frame_of(input logic [15:0] w);
`ifdef SPI_CMD_PARITY_EN
    return {15'h0, w, ~^w};
`else
    return {16'h0, w};
`endif
  endfunction

  task automatic send_word(input logic [15:0] w);
    spi_send(frame_of(w), FLen, 0);
  endtask

  int s_x, s_v, s_f, s_o;
  logic [31:0] lbits;

  task automatic snap();
    s_x = xfer_cnt;
    s_v = vcyc;
    s_f = frm_cnt;
    s_o = ovf_cnt;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_data", 32'(data), 32'h0);
    check_eq("rst_frm_err", 32'(frm_err), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);

    // Single frame, ready held high
    snap();
    send_word(16'hA5C3);
    check_eq("single_xfer", xfer_cnt - s_x, 1);
    check_eq("single_data", 32'(last_data), 32'hA5C3);
    check_eq("single_vcyc", vcyc - s_v, 1);
    check_eq("single_frm", frm_cnt - s_f, 0);
    check_eq("single_ovf", ovf_cnt - s_o, 0);
    check_eq("single_latency", valid_rise_cyc - last_rise_cyc, 3);

    // Backpressure and overflow
    ready = 1'b0;
    snap();
    send_word(16'h1234);
    check_eq("bp_valid1", 32'(valid), 32'h1);
    check_eq("bp_data1", 32'(data), 32'h1234);
    send_word(16'h5678);
    check_eq("bp_data2", 32'(data), 32'h1234);
    check_eq("bp_valid2", 32'(valid), 32'h1);
    check_eq("bp_ovf", ovf_cnt - s_o, 1);
    ready = 1'b1;
    tick(3);
    check_eq("bp_xfer", xfer_cnt - s_x, 1);
    check_eq("bp_xfer_data", 32'(last_data), 32'h1234);
    check_eq("bp_valid_after", 32'(valid), 32'h0);

    // Reset drops a pending word without overflow
    ready = 1'b0;
    send_word(16'h4242);
    check_eq("rstv_pending", 32'(valid), 32'h1);
    snap();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    check_eq("rstv_valid", 32'(valid), 32'h0);
    check_eq("rstv_data", 32'(data), 32'h0);
    check_eq("rstv_ovf", ovf_cnt - s_o, 0);
    ready = 1'b1;

    // Short frame, then a good one
    snap();
    spi_send(32'h1FF, 9, 0);
    check_eq("short_frm", frm_cnt - s_f, 1);
    check_eq("short_vcyc", vcyc - s_v, 0);
    send_word(16'h00FF);
    check_eq("short_next_xfer", xfer_cnt - s_x, 1);
    check_eq("short_next_data", 32'(last_data), 32'h00FF);

    // Long frame: 20 clocks
`ifdef SPI_CMD_PARITY_EN
    lbits = {12'h0, 16'hBEEF, ~^16'hBEEF, 3'b101};
`else
    lbits = {12'h0, 16'hBEEF, 4'hA};
`endif
    snap();
    spi_send(lbits, 20, 0);
    check_eq("long_xfer", xfer_cnt - s_x, 1);
    check_eq("long_data", 32'(last_data), 32'hBEEF);
    check_eq("long_frm", frm_cnt - s_f, 1);

    // Reset after bit 8 with CS still low
    snap();
    spi_send(frame_of(16'hCAFE), FLen, 8);
    check_eq("midrst_xfer", xfer_cnt - s_x, 0);
    check_eq("midrst_vcyc", vcyc - s_v, 0);
    send_word(16'h0F0F);
    check_eq("midrst_next_data", 32'(last_data), 32'h0F0F);

`ifdef SPI_CMD_PARITY_EN
    snap();
    spi_send({15'h0, 16'h0001, 1'b0}, 17, 0);
    check_eq("par_ok_xfer", xfer_cnt - s_x, 1);
    check_eq("par_ok_data", 32'(last_data), 32'h0001);
    snap();
    spi_send({15'h0, 16'h0001, 1'b1}, 17, 0);
    check_eq("par_bad_xfer", xfer_cnt - s_x, 0);
    check_eq("par_bad_frm", frm_cnt - s_f, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
